// File: rtl/vga_pkg.sv
// Shared VGA geometry, pixel-stream payload and ball controller state encoding.
package vga_pkg;

  localparam int unsigned HACTIVE = 800;
  localparam int unsigned VACTIVE = 600;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_UP    = 1'b0;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    MOVING = 2'd1,
    SCORED = 2'd2
  } ball_state_t;

  // One pixel of the draw chain: coordinates, sync/blank and colour
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               hblnk;
    logic               vsync;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_bus_t;

endpackage

// File: rtl/ball_ctl_if.sv
// Pixel-stream link between draw-chain stages; master drives, slave receives.
interface ball_ctl_if;
  import vga_pkg::*;

  vga_bus_t bus;

  modport master (output bus);
  modport slave  (input  bus);

endinterface

// File: rtl/ball_ctl_draw.sv
// One-cycle draw stage: delays the pixel stream and overlays the ball square.
module ball_draw
  import vga_pkg::*;
#(
  parameter int unsigned      BALL_SIZE = 16,
  parameter logic [RGB_W-1:0] BALL_RGB  = 12'hfff
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  ball_ctl_if.slave          vin,
  ball_ctl_if.master         vout
);

  localparam int unsigned EXT_W = COORD_W + 1;

  logic     in_x;
  logic     in_y;
  logic     on_ball;
  vga_bus_t px;

  // Extra bit keeps ball_x + BALL_SIZE from wrapping near the right edge
  always_comb begin
    in_x = ({1'b0, vin.bus.hcount} >= {1'b0, ball_x}) &&
           ({1'b0, vin.bus.hcount} < ({1'b0, ball_x} + EXT_W'(BALL_SIZE)));
    in_y = ({1'b0, vin.bus.vcount} >= {1'b0, ball_y}) &&
           ({1'b0, vin.bus.vcount} < ({1'b0, ball_y} + EXT_W'(BALL_SIZE)));
    on_ball = in_x && in_y && !vin.bus.hblnk && !vin.bus.vblnk;
    px = vin.bus;
    if (on_ball) px.rgb = BALL_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vout.bus <= '0;
    else        vout.bus <= px;
  end

endmodule

// File: rtl/ball_ctl.sv
// Pong ball controller: per-frame motion, wall/paddle bounces, scoring, and ball overlay.
module ball_ctl
  import vga_pkg::*;
#(
  parameter int unsigned      BALL_SIZE    = 16,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      SERVE_FRAMES = 60,
  parameter int unsigned      PADDLE_W     = 16,
  parameter int unsigned      PADDLE_H     = 96,
  parameter int unsigned      PADDLE_X_L   = 32,
  parameter int unsigned      PADDLE_X_R   = 752,
  parameter logic [RGB_W-1:0] BALL_RGB     = 12'hfff
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_en,
  input  logic               timing_tick,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  ball_ctl_if.slave          vin,
  ball_ctl_if.master         vout,
  output logic               point_l,
  output logic               point_r
);

  localparam int unsigned S_W   = 13;
  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [COORD_W-1:0] X0      = COORD_W'((HACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y0      = COORD_W'((VACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(VACTIVE - BALL_SIZE);
  localparam logic [COORD_W-1:0] X_L_HIT = COORD_W'(PADDLE_X_L + PADDLE_W);
  localparam logic [COORD_W-1:0] X_R_HIT = COORD_W'(PADDLE_X_R - BALL_SIZE);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SERVE_FRAMES - 1);

  localparam logic signed [S_W-1:0] STEP_S = S_W'(STEP);
  localparam logic signed [S_W-1:0] BS_S   = S_W'(BALL_SIZE);
  localparam logic signed [S_W-1:0] PH_S   = S_W'(PADDLE_H);
  localparam logic signed [S_W-1:0] PLE_S  = S_W'(PADDLE_X_L + PADDLE_W);
  localparam logic signed [S_W-1:0] PXR_S  = S_W'(PADDLE_X_R);
  localparam logic signed [S_W-1:0] HA_S   = S_W'(HACTIVE);
  localparam logic signed [S_W-1:0] VA_S   = S_W'(VACTIVE);
  localparam logic signed [S_W-1:0] ZERO_S = '0;

  ball_state_t        state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               dir_x;
  logic               dir_y;
  logic [CNT_W-1:0]   serve_cnt;

  logic signed [S_W-1:0] x_s, y_s, pl_s, pr_s;
  logic signed [S_W-1:0] nx, ny;
  logic                  hit_l, hit_r, miss_l, miss_r;
  logic [COORD_W-1:0]    x_nxt, y_nxt;
  logic                  dir_x_nxt, dir_y_nxt;

  assign x_s  = $signed({2'b00, x});
  assign y_s  = $signed({2'b00, y});
  assign pl_s = $signed({2'b00, paddle_l_y});
  assign pr_s = $signed({2'b00, paddle_r_y});

  // Candidate motion for the next tick; the two axes resolve independently
  always_comb begin
    nx = (dir_x == DIR_RIGHT) ? x_s + STEP_S : x_s - STEP_S;
    ny = (dir_y == DIR_DOWN)  ? y_s + STEP_S : y_s - STEP_S;

    hit_l = (dir_x == DIR_LEFT) && (x_s >= PLE_S) && (nx < PLE_S) &&
            (y_s + BS_S > pl_s) && (y_s < pl_s + PH_S);
    hit_r = (dir_x == DIR_RIGHT) && (nx + BS_S > PXR_S) && (x_s + BS_S <= PXR_S) &&
            (y_s + BS_S > pr_s) && (y_s < pr_s + PH_S);
    miss_l = !hit_l && !hit_r && (nx <= ZERO_S);
    miss_r = !hit_l && !hit_r && (nx + BS_S >= HA_S);

    x_nxt     = COORD_W'(nx);
    y_nxt     = COORD_W'(ny);
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;

    if (ny <= ZERO_S) begin
      y_nxt     = '0;
      dir_y_nxt = DIR_DOWN;
    end else if (ny + BS_S >= VA_S) begin
      y_nxt     = Y_MAX;
      dir_y_nxt = DIR_UP;
    end

    // On a miss the next serve heads toward the side that conceded
    if (hit_l) begin
      x_nxt     = X_L_HIT;
      dir_x_nxt = DIR_RIGHT;
    end else if (hit_r) begin
      x_nxt     = X_R_HIT;
      dir_x_nxt = DIR_LEFT;
    end else if (miss_l) begin
      dir_x_nxt = DIR_LEFT;
    end else if (miss_r) begin
      dir_x_nxt = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SERVE;
      x         <= X0;
      y         <= Y0;
      dir_x     <= DIR_RIGHT;
      dir_y     <= DIR_DOWN;
      serve_cnt <= '0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      if (!game_en) begin
        state     <= SERVE;
        x         <= X0;
        y         <= Y0;
        serve_cnt <= '0;
      end else begin
        unique case (state)
          SERVE: begin
            x <= X0;
            y <= Y0;
            if (timing_tick) begin
              if (serve_cnt == CNT_END) begin
                state     <= MOVING;
                serve_cnt <= '0;
              end else begin
                serve_cnt <= serve_cnt + CNT_W'(1);
              end
            end
          end
          MOVING: begin
            if (timing_tick) begin
              x     <= x_nxt;
              y     <= y_nxt;
              dir_x <= dir_x_nxt;
              dir_y <= dir_y_nxt;
              if (miss_l) begin
                point_r <= 1'b1;
                state   <= SCORED;
              end else if (miss_r) begin
                point_l <= 1'b1;
                state   <= SCORED;
              end
            end
          end
          SCORED: begin
            x     <= X0;
            y     <= Y0;
            state <= SERVE;
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

  ball_draw #(
    .BALL_SIZE (BALL_SIZE),
    .BALL_RGB  (BALL_RGB)
  ) u_draw (
    .clk    (clk),
    .rst_n  (rst_n),
    .ball_x (x),
    .ball_y (y),
    .vin    (vin),
    .vout   (vout)
  );

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: ball position is observed through the rendered overlay.
module tb_ball_ctl;
  import vga_pkg::*;

  localparam logic [11:0] BG   = 12'h0a5;
  localparam logic [11:0] BALL = 12'hfff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_en;
  logic        timing_tick;
  logic [10:0] paddle_l_y;
  logic [10:0] paddle_r_y;
  logic        point_l;
  logic        point_r;

  int errors = 0;
  int checks = 0;

  ball_ctl_if vin_if ();
  ball_ctl_if vout_if ();

  ball_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_en     (game_en),
    .timing_tick (timing_tick),
    .paddle_l_y  (paddle_l_y),
    .paddle_r_y  (paddle_r_y),
    .vin         (vin_if),
    .vout        (vout_if),
    .point_l     (point_l),
    .point_r     (point_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    vin_if.bus.hcount = '0;
    vin_if.bus.vcount = '0;
    vin_if.bus.hsync  = 1'b0;
    vin_if.bus.hblnk  = 1'b1;
    vin_if.bus.vsync  = 1'b0;
    vin_if.bus.vblnk  = 1'b1;
    vin_if.bus.rgb    = BG;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      timing_tick = 1'b1;
      @(posedge clk); #1;
      timing_tick = 1'b0;
    end
  endtask

  task automatic probe(input string tag, input int h, input int v, input logic blank,
                       input logic [11:0] exp);
    @(posedge clk); #1;
    vin_if.bus.hcount = 11'(h);
    vin_if.bus.vcount = 11'(v);
    vin_if.bus.hblnk  = blank;
    vin_if.bus.vblnk  = 1'b0;
    vin_if.bus.rgb    = BG;
    @(posedge clk); #1;
    chk(tag, 32'(vout_if.bus.rgb), 32'(exp));
    idle_bus();
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    probe({tag, ".tl"},    ex,      ey,      1'b0, BALL);
    probe({tag, ".br"},    ex + 15, ey + 15, 1'b0, BALL);
    probe({tag, ".left"},  ex - 1,  ey,      1'b0, BG);
    probe({tag, ".right"}, ex + 16, ey,      1'b0, BG);
    probe({tag, ".above"}, ex,      ey - 1,  1'b0, BG);
  endtask

  initial begin
    rst_n       = 1'b0;
    game_en     = 1'b0;
    timing_tick = 1'b0;
    paddle_l_y  = 11'd400;
    paddle_r_y  = 11'd500;
    idle_bus();
    vin_if.bus.hcount = 11'd77;
    vin_if.bus.hsync  = 1'b1;
    vin_if.bus.rgb    = 12'h3c3;
    step(3);

    chk("rst.rgb",     32'(vout_if.bus.rgb), 32'h0);
    chk("rst.hcount",  32'(vout_if.bus.hcount), 32'h0);
    chk("rst.hsync",   32'(vout_if.bus.hsync), 32'h0);
    chk("rst.hblnk",   32'(vout_if.bus.hblnk), 32'h0);
    chk("rst.point_l", 32'(point_l), 32'h0);
    chk("rst.point_r", 32'(point_r), 32'h0);

    idle_bus();
    rst_n   = 1'b1;
    game_en = 1'b1;
    step(1);

    // Serve from centre: 60 ticks idle, first move on tick 61
    check_pos("serve0", 392, 292);
    tick(59);
    check_pos("serve59", 392, 292);
    tick(1);
    check_pos("serve60", 392, 292);
    tick(1);
    check_pos("move1", 396, 296);

    // Pixel stream passes through one clock late
    @(posedge clk); #1;
    vin_if.bus.hcount = 11'h2aa;
    vin_if.bus.vcount = 11'h155;
    vin_if.bus.hsync  = 1'b1;
    vin_if.bus.hblnk  = 1'b0;
    vin_if.bus.vsync  = 1'b1;
    vin_if.bus.vblnk  = 1'b1;
    vin_if.bus.rgb    = 12'h123;
    @(posedge clk); #1;
    chk("pt.hcount", 32'(vout_if.bus.hcount), 32'h2aa);
    chk("pt.vcount", 32'(vout_if.bus.vcount), 32'h155);
    chk("pt.hsync",  32'(vout_if.bus.hsync), 32'h1);
    chk("pt.hblnk",  32'(vout_if.bus.hblnk), 32'h0);
    chk("pt.vsync",  32'(vout_if.bus.vsync), 32'h1);
    chk("pt.vblnk",  32'(vout_if.bus.vblnk), 32'h1);
    chk("pt.rgb",    32'(vout_if.bus.rgb), 32'h123);
    idle_bus();
    probe("hblnk_on_ball", 396, 296, 1'b1, BG);

    // Bottom wall, then right paddle bounce
    tick(72);
    check_pos("wall_bot", 684, 584);
    tick(1);
    check_pos("after_bot", 688, 580);
    tick(12);
    check_pos("pre_rpad", 736, 532);
    tick(1);
    check_pos("rpad_hit", 736, 528);
    tick(1);
    check_pos("after_rpad", 732, 524);

    // Top wall, then pass the left paddle with no overlap and exit left
    tick(132);
    check_pos("after_top", 204, 4);
    tick(39);
    check_pos("at_lpad", 48, 160);
    tick(1);
    check_pos("lpad_miss", 44, 164);
    tick(10);
    check_pos("near_left", 4, 204);
    tick(1);
    chk("exitL.point_r", 32'(point_r), 32'h1);
    chk("exitL.point_l", 32'(point_l), 32'h0);
    step(1);
    chk("exitL.point_r_end", 32'(point_r), 32'h0);
    check_pos("recentre_L", 392, 292);

    // Next serve heads left after the full serve delay
    paddle_l_y = 11'd520;
    tick(60);
    check_pos("serveL60", 392, 292);
    tick(1);
    check_pos("serveL_move", 388, 296);
    tick(72);
    check_pos("wall_bot2", 100, 584);
    tick(13);
    check_pos("pre_lpad", 48, 532);
    tick(1);
    check_pos("lpad_hit", 48, 528);
    tick(1);
    check_pos("after_lpad", 52, 524);

    // game_en drop recentres and restarts the serve count
    game_en = 1'b0;
    step(2);
    check_pos("gen_off", 392, 292);
    game_en = 1'b1;
    step(1);
    tick(60);
    check_pos("gen_serve60", 392, 292);
    tick(1);
    check_pos("gen_move", 396, 288);

    // Asynchronous reset mid-flight
    tick(5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst.rgb",   32'(vout_if.bus.rgb), 32'h0);
    chk("arst.hblnk", 32'(vout_if.bus.hblnk), 32'h0);
    step(2);
    rst_n = 1'b1;
    paddle_r_y = 11'd0;
    step(1);
    check_pos("arst_centre", 392, 292);
    tick(60);
    check_pos("arst_serve60", 392, 292);
    tick(1);
    check_pos("arst_move", 396, 296);

    // Right paddle out of reach: ball exits right
    tick(96);
    check_pos("near_right", 780, 488);
    tick(1);
    chk("exitR.point_l", 32'(point_l), 32'h1);
    chk("exitR.point_r", 32'(point_r), 32'h0);
    step(1);
    chk("exitR.point_l_end", 32'(point_l), 32'h0);
    check_pos("recentre_R", 392, 292);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
